// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_pkg
// Description : Shared encodings and defaults for the fetch stage: next-PC
//               select codes, fetch FSM states, reset PC / NOP defaults and
//               a sign-extension helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

    // Next-PC select encodings driven by the D-stage control
    typedef enum logic [1:0] {
        NPC_SEQ = 2'd0,
        NPC_BR  = 2'd1,
        NPC_J   = 2'd2,
        NPC_JR  = 2'd3
    } npc_sel_e;

    // Fetch unit state
    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEF_NOP_WORD = 32'h0000_0000;
    localparam int unsigned DEF_IM_WORDS = 1024;

    // Sign-extend a 16-bit immediate to 32 bits
    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage_npc_calc.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_npc_calc
// Description : Combinational branch / jump / jr target generation and
//               next-PC selection. Targets come from the IF/ID contents, so
//               the redirect is resolved while the branch sits in D.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage_npc_calc
    import fetch_stage_pkg::*;
(
    input  logic [31:0] pc_f_i,
    input  logic [31:0] pc_d_i,
    input  logic [25:0] instr_idx_i,   // instr_d[25:0]; upper opcode bits unused here
    input  logic [1:0]  npc_sel_i,
    input  logic        br_taken_i,
    input  logic [31:0] jr_addr_i,
    output logic [31:0] npc_o,
    output logic        redirect_o     // npc is a taken redirect, not pc_f+4
);

    logic [31:0] w_seq_pc;
    logic [31:0] w_br_tgt;
    logic [31:0] w_j_tgt;

    assign w_seq_pc = pc_f_i + 32'd4;
    assign w_br_tgt = pc_d_i + 32'd4 + (sext16(instr_idx_i[15:0]) << 2);
    assign w_j_tgt  = {pc_d_i[31:28], instr_idx_i, 2'b00};

    // Select next PC; a not-taken branch falls through to the sequential PC
    always_comb begin
        npc_o      = w_seq_pc;
        redirect_o = 1'b0;
        case (npc_sel_i)
            NPC_BR: begin
                if (br_taken_i) begin
                    npc_o      = w_br_tgt;
                    redirect_o = 1'b1;
                end
            end
            NPC_J: begin
                npc_o      = w_j_tgt;
                redirect_o = 1'b1;
            end
            NPC_JR: begin
                npc_o      = jr_addr_i;
                redirect_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch stage. Owns the PC, drives the ROM fetch
//               address, registers the returned word into IF/ID and handles
//               stalls, flushes and out-of-range fetches (RUN/HALT FSM).
//               Optional build macro FETCH_PERF_CNT_EN adds fetch_cnt and
//               stall_cnt performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter int unsigned IM_WORDS = DEF_IM_WORDS,
    parameter logic [31:0] NOP_WORD = DEF_NOP_WORD
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        flush,
    input  logic [1:0]  npc_sel,
    input  logic        br_taken,
    input  logic [31:0] jr_addr,
    output logic [31:0] im_pc,
    input  logic [31:0] im_instr,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc8_d,
    output logic        valid_d,
    output logic        adel_d,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt,
`endif
    output logic        halted
);

    // One past the last legal fetch address, kept 33 bits wide so a memory
    // ending at 2^32 cannot wrap the bound.
    localparam logic [32:0] PC_LIMIT = {1'b0, RESET_PC} + ({1'b0, 32'(IM_WORDS)} << 2);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_f_q, pc_f_d;
    logic [31:0]  ifid_instr_q, ifid_instr_d;
    logic [31:0]  ifid_pc_q, ifid_pc_d;
    logic [31:0]  ifid_pc8_q, ifid_pc8_d;
    logic         ifid_valid_q, ifid_valid_d;
    logic         ifid_adel_q, ifid_adel_d;

    logic [31:0]  w_npc;
    logic         w_redirect;
    logic         w_fetch_err;
    logic [31:0]  w_pc_f_plus8;

    assign w_pc_f_plus8 = pc_f_q + 32'd8;
    assign w_fetch_err  = (pc_f_q[1:0] != 2'b00)
                       || (pc_f_q < RESET_PC)
                       || ({1'b0, pc_f_q} >= PC_LIMIT);

    fetch_stage_npc_calc u_npc_calc (
        .pc_f_i      (pc_f_q),
        .pc_d_i      (ifid_pc_q),
        .instr_idx_i (ifid_instr_q[25:0]),
        .npc_sel_i   (npc_sel),
        .br_taken_i  (br_taken),
        .jr_addr_i   (jr_addr),
        .npc_o       (w_npc),
        .redirect_o  (w_redirect)
    );

    // State, PC and IF/ID registers; reset wins over any in-flight update
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= RUN;
            pc_f_q       <= RESET_PC;
            ifid_instr_q <= NOP_WORD;
            ifid_pc_q    <= RESET_PC;
            ifid_pc8_q   <= RESET_PC + 32'd8;
            ifid_valid_q <= 1'b0;
            ifid_adel_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_f_q       <= pc_f_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc8_q   <= ifid_pc8_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_adel_q  <= ifid_adel_d;
        end
    end

    // Next-state logic: PC advance, IF/ID load and RUN/HALT transitions
    always_comb begin
        state_d      = state_q;
        pc_f_d       = pc_f_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc8_d   = ifid_pc8_q;
        ifid_valid_d = ifid_valid_q;
        ifid_adel_d  = ifid_adel_q;

        case (state_q)
            RUN: begin
                if (!stall) begin
                    pc_f_d       = w_npc;
                    ifid_instr_d = im_instr;
                    ifid_pc_d    = pc_f_q;
                    ifid_pc8_d   = w_pc_f_plus8;
                    ifid_valid_d = 1'b1;
                    ifid_adel_d  = 1'b0;
                    if (w_fetch_err) begin
                        // Faulting entry still flows down so D can raise AdEL
                        ifid_instr_d = NOP_WORD;
                        ifid_adel_d  = 1'b1;
                        state_d      = HALT;
                    end
                end
            end
            HALT: begin
                if (!stall) begin
                    ifid_instr_d = NOP_WORD;
                    ifid_pc_d    = pc_f_q;
                    ifid_pc8_d   = w_pc_f_plus8;
                    ifid_valid_d = 1'b0;
                    ifid_adel_d  = 1'b0;
                    // A late redirect (e.g. branch whose delay slot faulted) restarts fetch
                    if (w_redirect) begin
                        pc_f_d  = w_npc;
                        state_d = RUN;
                    end
                end
            end
            default: state_d = RUN;
        endcase

        // Flush bubbles IF/ID even under stall; the PC path is unaffected
        if (flush) begin
            ifid_instr_d = NOP_WORD;
            ifid_pc_d    = pc_f_q;
            ifid_pc8_d   = w_pc_f_plus8;
            ifid_valid_d = 1'b0;
            ifid_adel_d  = 1'b0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;
    logic        w_valid_load;

    assign w_valid_load = (state_q == RUN) && !stall && !flush;

    // Performance counters: valid IF/ID loads and stalled cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            if (w_valid_load) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (stall)        stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

    assign im_pc   = pc_f_q;
    assign instr_d = ifid_instr_q;
    assign pc_d    = ifid_pc_q;
    assign pc8_d   = ifid_pc8_q;
    assign valid_d = ifid_valid_q;
    assign adel_d  = ifid_adel_q;
    assign halted  = (state_q == HALT);

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage. Expected IF/ID entries
//               are queued as each cycle is driven and compared after the
//               clock edge; PC and halt status are checked against constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        flush;
    logic [1:0]  npc_sel;
    logic        br_taken;
    logic [31:0] jr_addr;
    logic [31:0] im_pc;
    logic [31:0] im_instr;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc8_d;
    logic        valid_d;
    logic        adel_d;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic        adel;
        bit          chk_pc;
    } exp_t;

    exp_t sb[$];

    logic [31:0] rom [0:1023];

    always #5 clk = ~clk;

    assign im_instr = rom[im_pc[11:2]];

    fetch_stage dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .stall    (stall),
        .flush    (flush),
        .npc_sel  (npc_sel),
        .br_taken (br_taken),
        .jr_addr  (jr_addr),
        .im_pc    (im_pc),
        .im_instr (im_instr),
        .instr_d  (instr_d),
        .pc_d     (pc_d),
        .pc8_d    (pc8_d),
        .valid_d  (valid_d),
        .adel_d   (adel_d),
`ifdef FETCH_PERF_CNT_EN
        .fetch_cnt(fetch_cnt),
        .stall_cnt(stall_cnt),
`endif
        .halted   (halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] i, input logic [31:0] p,
                        input logic v, input logic a, input bit cp);
        exp_t e;
        e.instr  = i;
        e.pc     = p;
        e.valid  = v;
        e.adel   = a;
        e.chk_pc = cp;
        sb.push_back(e);
    endtask

    // Drive one cycle of controls, clock it, then compare IF/ID to the queue head
    task automatic cyc(input logic s, input logic f, input logic [1:0] sel,
                       input logic br, input logic [31:0] jr);
        exp_t e;
        stall    = s;
        flush    = f;
        npc_sel  = sel;
        br_taken = br;
        jr_addr  = jr;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            chk("instr_d", instr_d, e.instr);
            chk("valid_d", 32'(valid_d), 32'(e.valid));
            chk("adel_d",  32'(adel_d),  32'(e.adel));
            if (e.chk_pc) begin
                chk("pc_d",  pc_d,  e.pc);
                chk("pc8_d", pc8_d, e.pc + 32'd8);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 32'h2400_0000 | 32'(i);
        rom[1] = 32'h1000_0003;   // beq, imm = 3
        rom[7] = 32'h0800_0C10;   // j 0x3040

        reset_n = 1'b0; stall = 1'b0; flush = 1'b0;
        npc_sel = 2'd0; br_taken = 1'b0; jr_addr = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc_f",    im_pc,   32'h0000_3000);
        chk("rst_instr_d", instr_d, 32'h0000_0000);
        chk("rst_pc_d",    pc_d,    32'h0000_3000);
        chk("rst_pc8_d",   pc8_d,   32'h0000_3008);
        chk("rst_valid",   32'(valid_d), 32'd0);
        chk("rst_adel",    32'(adel_d),  32'd0);
        chk("rst_halted",  32'(halted),  32'd0);
        reset_n = 1'b1;

        // Free-running fetch
        push(32'h2400_0000, 32'h3000, 1'b1, 1'b0, 1'b1); cyc(0, 0, 2'd0, 0, 32'd0);
        chk("pc_f_seq1", im_pc, 32'h3004);
        push(32'h1000_0003, 32'h3004, 1'b1, 1'b0, 1'b1); cyc(0, 0, 2'd0, 0, 32'd0);
        chk("pc_f_seq2", im_pc, 32'h3008);
        // beq in D taken: delay slot enters, then target 0x3014
        push(32'h2400_0002, 32'h3008, 1'b1, 1'b0, 1'b1); cyc(0, 0, 2'd1, 1, 32'd0);
        chk("pc_f_br", im_pc, 32'h3014);
        push(32'h2400_0005, 32'h3014, 1'b1, 1'b0, 1'b1); cyc(0, 0, 2'd0, 0, 32'd0);
        chk("pc_f_after_br", im_pc, 32'h3018);
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_cnt_4", fetch_cnt, 32'd4);
        chk("stall_cnt_0", stall_cnt, 32'd0);
`endif

        // Two stalled cycles with an ignored jump request
        push(32'h2400_0005, 32'h3014, 1'b1, 1'b0, 1'b1); cyc(1, 0, 2'd2, 0, 32'd0);
        chk("pc_f_stall1", im_pc, 32'h3018);
        push(32'h2400_0005, 32'h3014, 1'b1, 1'b0, 1'b1); cyc(1, 0, 2'd2, 0, 32'd0);
        chk("pc_f_stall2", im_pc, 32'h3018);
`ifdef FETCH_PERF_CNT_EN
        chk("stall_cnt_2", stall_cnt, 32'd2);
        chk("fetch_cnt_hold", fetch_cnt, 32'd4);
`endif
        push(32'h2400_0006, 32'h3018, 1'b1, 1'b0, 1'b1); cyc(0, 0, 2'd0, 0, 32'd0);
        chk("pc_f_resume", im_pc, 32'h301C);

        // Jump to 0x3040 with its delay slot
        push(32'h0800_0C10, 32'h301C, 1'b1, 1'b0, 1'b1); cyc(0, 0, 2'd0, 0, 32'd0);
        chk("pc_f_j_fetch", im_pc, 32'h3020);
        push(32'h2400_0008, 32'h3020, 1'b1, 1'b0, 1'b1); cyc(0, 0, 2'd2, 0, 32'd0);
        chk("pc_f_jump", im_pc, 32'h3040);

        // flush with stall: bubble, PC holds
        push(32'h0000_0000, 32'h3040, 1'b0, 1'b0, 1'b1); cyc(1, 1, 2'd0, 0, 32'd0);
        chk("pc_f_flush_stall", im_pc, 32'h3040);
        // flush together with a jr redirect: both take effect
        push(32'h0000_0000, 32'h3040, 1'b0, 1'b0, 1'b1); cyc(0, 1, 2'd3, 0, 32'h3080);
        chk("pc_f_flush_jr", im_pc, 32'h3080);
        push(32'h2400_0020, 32'h3080, 1'b1, 1'b0, 1'b1); cyc(0, 0, 2'd0, 0, 32'd0);
        chk("pc_f_after_flush", im_pc, 32'h3084);
        // branch not taken falls through
        push(32'h2400_0021, 32'h3084, 1'b1, 1'b0, 1'b1); cyc(0, 0, 2'd1, 0, 32'd0);
        chk("pc_f_br_nt", im_pc, 32'h3088);

        // jr to a misaligned address
        push(32'h2400_0022, 32'h3088, 1'b1, 1'b0, 1'b1); cyc(0, 0, 2'd3, 0, 32'h3001);
        chk("pc_f_jr_bad", im_pc, 32'h3001);
        push(32'h0000_0000, 32'h3001, 1'b1, 1'b1, 1'b1); cyc(0, 0, 2'd0, 0, 32'd0);
        chk("halted_misalign", 32'(halted), 32'd1);
        push(32'h0000_0000, 32'h0, 1'b0, 1'b0, 1'b0); cyc(0, 0, 2'd0, 0, 32'd0);
        chk("halted_bubble", 32'(halted), 32'd1);
        // stalled redirect in HALT is ignored
        push(32'h0000_0000, 32'h0, 1'b0, 1'b0, 1'b0); cyc(1, 0, 2'd3, 0, 32'h3100);
        chk("halted_stall", 32'(halted), 32'd1);
        // unstalled redirect leaves HALT
        push(32'h0000_0000, 32'h0, 1'b0, 1'b0, 1'b0); cyc(0, 0, 2'd3, 0, 32'h3100);
        chk("pc_f_halt_redirect", im_pc, 32'h3100);
        chk("halted_cleared", 32'(halted), 32'd0);
        push(32'h2400_0040, 32'h3100, 1'b1, 1'b0, 1'b1); cyc(0, 0, 2'd0, 0, 32'd0);
        chk("pc_f_after_halt", im_pc, 32'h3104);

        // Asynchronous reset in mid-cycle
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_pc_f",  im_pc, 32'h3000);
        chk("async_rst_valid", 32'(valid_d), 32'd0);
        chk("async_rst_pc_d",  pc_d, 32'h3000);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Sequential run off the end of memory
        push(32'h2400_0000, 32'h3000, 1'b1, 1'b0, 1'b1); cyc(0, 0, 2'd3, 0, 32'h3FF8);
        chk("pc_f_jr_end", im_pc, 32'h3FF8);
        push(32'h2400_03FE, 32'h3FF8, 1'b1, 1'b0, 1'b1); cyc(0, 0, 2'd0, 0, 32'd0);
        chk("pc_f_3ffc", im_pc, 32'h3FFC);
        push(32'h2400_03FF, 32'h3FFC, 1'b1, 1'b0, 1'b1); cyc(0, 0, 2'd0, 0, 32'd0);
        chk("pc_f_4000", im_pc, 32'h4000);
        chk("halted_before_end", 32'(halted), 32'd0);
        push(32'h0000_0000, 32'h4000, 1'b1, 1'b1, 1'b1); cyc(0, 0, 2'd0, 0, 32'd0);
        chk("halted_end", 32'(halted), 32'd1);

        // Top of the address space: out of range, pc8 wraps
        push(32'h0000_0000, 32'h0, 1'b0, 1'b0, 1'b0); cyc(0, 0, 2'd3, 0, 32'hFFFF_FFFC);
        chk("pc_f_top", im_pc, 32'hFFFF_FFFC);
        chk("halted_top_run", 32'(halted), 32'd0);
        push(32'h0000_0000, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b1); cyc(0, 0, 2'd0, 0, 32'd0);
        chk("halted_top", 32'(halted), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the P5 pipelined MIPS core, directly upstream of the instruction ROM.
- Owns the PC register and computes the next PC: sequential, branch, jump and jr targets, with the redirect taken in D.
- Drives the fetch address to the ROM, samples the returned word, and registers it into the IF/ID pipeline register.
- Handles hazard stalls, flushes and out-of-range fetches.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded at reset; base of instruction memory.
- IM_WORDS, 1024, instruction memory depth in words; legal PC range is [RESET_PC, RESET_PC+4*IM_WORDS).
- NOP_WORD, 32'h0000_0000, word injected into IF/ID on flush or fetch error.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- stall  in  1  hazard-unit stall; holds the PC and IF/ID.
- flush  in  1  clears IF/ID to a bubble.
- npc_sel  in  2  next-PC select: 0 = pc_f+4, 1 = branch, 2 = jump (j/jal), 3 = jr.
- br_taken  in  1  D-stage comparator result; used only when npc_sel = 1.
- jr_addr  in  32  forwarded rs value for jr/jalr.
- im_pc  out  32  fetch address to ROM, equal to pc_f; the ROM indexes [11:2].
- im_instr  in  32  ROM read data, combinational from im_pc.
- instr_d  out  32  IF/ID instruction.
- pc_d  out  32  IF/ID PC.
- pc8_d  out  32  pc_d+8, the link value for jal/jalr.
- valid_d  out  1  IF/ID holds a real instruction.
- adel_d  out  1  IF/ID entry came from an illegal fetch address.
- halted  out  1  fetch unit is in HALT.

Behaviour:
- Reset, asynchronous while reset_n = 0:
  - pc_f = RESET_PC, state = RUN.
  - instr_d = NOP_WORD, pc_d = RESET_PC, pc8_d = RESET_PC+8.
  - valid_d = 0, adel_d = 0, halted = 0.
  - Reset asserted mid-operation overrides every in-flight update.
- Latency: an instruction appears in IF/ID one cycle after its PC is in pc_f.
- Targets, computed from IF/ID contents:
  - Branch: pc_d+4+(sext(instr_d[15:0])<<2).
  - Jump: {pc_d[31:28], instr_d[25:0], 2'b00}.
  - All sums are 32-bit modulo 2^32.
- Next-PC mux:
  - npc_sel = 1 with br_taken = 0 selects pc_f+4.
  - The branch delay slot is architectural: the instruction already in pc_f is never squashed by a redirect.
- Fetch legality: fetch_err = (pc_f[1:0] != 0) or pc_f < RESET_PC or pc_f >= RESET_PC+4*IM_WORDS.
- RUN state, stall = 0:
  - pc_f <= npc.
  - IF/ID <= {im_instr, pc_f, pc_f+8, valid = 1, adel = 0}.
  - If fetch_err: IF/ID <= {NOP_WORD, pc_f, pc_f+8, valid = 1, adel = 1}, state <= HALT.
- RUN state, stall = 1:
  - pc_f and IF/ID hold.
  - Redirect requests are ignored; the hazard unit re-presents them once the stall clears.
- HALT state:
  - pc_f frozen, halted = 1.
  - Each non-stalled cycle loads IF/ID with NOP_WORD, valid = 0, adel = 0.
  - A redirect (npc_sel != 0, taken) while in HALT with stall = 0 loads pc_f <= npc and returns to RUN. This covers a branch whose delay slot ran off the end of memory.
- flush:
  - IF/ID <= {NOP_WORD, pc_f, pc_f+8, valid = 0, adel = 0} regardless of stall.
  - The PC still obeys stall.
  - flush and a redirect in the same cycle: both take effect.
- Sequential PC wrap: 32'hFFFF_FFFC+4 = 0 is out of range, so it flags adel and enters HALT.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, adds outputs:
  - fetch_cnt (32): increments on every IF/ID load with valid = 1.
  - stall_cnt (32): increments on every cycle with stall = 1 and reset_n = 1.
  - Both reset to 0 and wrap modulo 2^32.
- When undefined, neither port nor counter exists and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - NPC_SEQ/NPC_BR/NPC_J/NPC_JR encodings (0..3).
  - RUN/HALT state encoding.
  - RESET_PC and NOP_WORD defaults.
- Natural sub-module: npc_calc, the combinational target and next-PC selection from pc_f, pc_d, instr_d, npc_sel, br_taken and jr_addr.
- The PC register, the IF/ID register and the FSM stay in fetch_stage.

Test Plan:
- Reset, then three free-running cycles with ROM words A, B, C → pc_f 0x3000, 0x3004, 0x3008; instr_d = A then B with pc_d 0x3000 then 0x3004; pc8_d = 0x3008 on the first fetch.
- beq at 0x3004 with imm 0x0003, br_taken = 1 when it is in D → delay slot 0x3008 enters IF/ID, then pc_f = 0x3014.
- stall held 2 cycles mid-stream → pc_f, instr_d and pc_d unchanged for 2 cycles; stall_cnt += 2 with FETCH_PERF_CNT_EN defined.
- jr with jr_addr = 0x3001 → fetch at 0x3001 gives adel_d = 1 with NOP in IF/ID, halted = 1, and bubbles follow; a later reset_n low returns pc_f to 0x3000.
- Sequential run to 0x3FFC then 0x4000 → 0x3FFC fetched normally; 0x4000 flags adel and HALTs.
- flush and stall asserted together → IF/ID becomes a bubble with valid_d = 0 while pc_f holds.
